// File: rtl/tgc_pkg.sv
// Shared types and constants for the GMII traffic generator/checker.
// Payload mode is selected by TGC_LFSR_PAYLOAD_EN (see tgc_payload_gen).
package tgc_pkg;
  typedef enum logic [2:0] {G_IDLE, G_PRE, G_SFD, G_DATA, G_IPG} gen_state_t;
  typedef enum logic [1:0] {C_IDLE, C_HUNT, C_DATA} chk_state_t;

  localparam logic [7:0] PRE_BYTE  = 8'h55;
  localparam logic [7:0] SFD_BYTE  = 8'hD5;
  // x^8+x^6+x^5+x^4+1 as a Fibonacci shift-left: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] SEED_XOR  = 8'hA5;

  function automatic logic [7:0] lfsr_seed(input logic [7:0] seq);
    return seq ^ SEED_XOR;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/gmii_traffic_gen_check_if.sv
// GMII transmit/receive bundle between the traffic generator/checker and the PCS.
interface gmii_traffic_gen_check_if;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic       RX_DV;
  logic [7:0] RXD;

  modport master (output TXD, TX_EN, TX_ER, input RX_DV, RXD);
  modport slave  (input TXD, TX_EN, TX_ER, output RX_DV, RXD);
endinterface

// File: rtl/tgc_payload_gen.sv
// Payload byte source shared by generator and checker: load(seq) then step per byte.
// TGC_LFSR_PAYLOAD_EN selects the LFSR sequence; otherwise bytes count up from seq.
module tgc_payload_gen
  import tgc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seq,
  output logic [7:0] data
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= 8'h00;
    end else if (load) begin
`ifdef TGC_LFSR_PAYLOAD_EN
      data <= lfsr_seed(seq);
`else
      data <= seq;
`endif
    end else if (step) begin
`ifdef TGC_LFSR_PAYLOAD_EN
      data <= lfsr_next(data);
`else
      data <= data + 8'd1;
`endif
    end
  end
endmodule

// File: rtl/gmii_traffic_gen_check.sv
// GMII framed burst generator plus receive-side payload checker with saturating counters.
// Payload pattern chosen at build time by TGC_LFSR_PAYLOAD_EN.
module gmii_traffic_gen_check
  import tgc_pkg::*;
#(
  parameter int FRAME_LEN    = 8,
  parameter int IPG          = 12,
  parameter int NUM_FRAMES   = 4,
  parameter int PREAMBLE_LEN = 7,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  gmii_traffic_gen_check_if.master gmii,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     frames_tx,
  output logic [CNT_W-1:0]     frames_rx,
  output logic [CNT_W-1:0]     byte_errs,
  output logic [CNT_W-1:0]     len_errs
);
  localparam int GCW = 16;
  localparam int IW  = $clog2(FRAME_LEN + 2);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  gen_state_t     gst;
  logic [GCW-1:0] gcnt;
  logic           run_started;
  logic           start_acc, more_frames, g_load, g_step;
  logic [7:0]     g_byte;

  assign start_acc   = start && (gst == G_IDLE);
  assign more_frames = (NUM_FRAMES == 0) || (frames_tx < CNT_W'(NUM_FRAMES));
  assign g_load      = (gst == G_PRE) && (gcnt == GCW'(PREAMBLE_LEN - 1));
  assign g_step      = (gst == G_SFD) || (gst == G_DATA);
  assign busy        = (gst != G_IDLE);
  assign gmii.TX_ER  = 1'b0;

  tgc_payload_gen u_gen_pay (
    .clk(clk), .reset_n(reset_n), .load(g_load), .step(g_step),
    .seq(frames_tx[7:0]), .data(g_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gst         <= G_IDLE;
      gcnt        <= '0;
      gmii.TXD    <= 8'h00;
      gmii.TX_EN  <= 1'b0;
      frames_tx   <= '0;
      run_started <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (gst == G_IDLE) && run_started && (NUM_FRAMES != 0) &&
              (frames_rx >= CNT_W'(NUM_FRAMES));
      case (gst)
        G_IDLE: if (start) begin
          gst         <= G_PRE;
          gcnt        <= '0;
          gmii.TX_EN  <= 1'b1;
          gmii.TXD    <= PRE_BYTE;
          frames_tx   <= '0;
          run_started <= 1'b1;
          done        <= 1'b0;
        end
        G_PRE: if (g_load) begin
          gst      <= G_SFD;
          gmii.TXD <= SFD_BYTE;
        end else begin
          gcnt     <= gcnt + 1'b1;
        end
        G_SFD: begin
          gst      <= G_DATA;
          gcnt     <= '0;
          gmii.TXD <= g_byte;
        end
        G_DATA: if (gcnt == GCW'(FRAME_LEN - 1)) begin
          gst        <= G_IPG;
          gcnt       <= '0;
          gmii.TX_EN <= 1'b0;
          gmii.TXD   <= 8'h00;
          frames_tx  <= sat_inc(frames_tx);
        end else begin
          gcnt     <= gcnt + 1'b1;
          gmii.TXD <= g_byte;
        end
        G_IPG: if (gcnt == GCW'(IPG - 1)) begin
          gcnt <= '0;
          if (more_frames) begin
            gst        <= G_PRE;
            gmii.TX_EN <= 1'b1;
            gmii.TXD   <= PRE_BYTE;
          end else begin
            gst <= G_IDLE;
          end
        end else begin
          gcnt <= gcnt + 1'b1;
        end
        default: gst <= G_IDLE;
      endcase
    end
  end

  chk_state_t    cst;
  logic [IW-1:0] cidx;
  logic          dv_q, c_load, c_step;
  logic [7:0]    c_byte;

  assign c_load = (cst == C_HUNT) && gmii.RX_DV && (gmii.RXD == SFD_BYTE);
  assign c_step = (cst == C_DATA) && gmii.RX_DV && (cidx < IW'(FRAME_LEN));

  tgc_payload_gen u_chk_pay (
    .clk(clk), .reset_n(reset_n), .load(c_load), .step(c_step),
    .seq(frames_rx[7:0]), .data(c_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cst       <= C_IDLE;
      cidx      <= '0;
      dv_q      <= 1'b0;
      frames_rx <= '0;
      byte_errs <= '0;
      len_errs  <= '0;
    end else begin
      dv_q <= gmii.RX_DV;
      case (cst)
        C_IDLE: if (gmii.RX_DV && !dv_q) cst <= C_HUNT;
        C_HUNT: if (!gmii.RX_DV) begin
          cst      <= C_IDLE;
          len_errs <= sat_inc(len_errs);
        end else if (gmii.RXD == SFD_BYTE) begin
          cst  <= C_DATA;
          cidx <= '0;
        end
        C_DATA: if (!gmii.RX_DV) begin
          cst       <= C_IDLE;
          frames_rx <= sat_inc(frames_rx);
          if (cidx != IW'(FRAME_LEN)) len_errs <= sat_inc(len_errs);
        end else if (cidx < IW'(FRAME_LEN)) begin
          cidx <= cidx + 1'b1;
          if (gmii.RXD != c_byte) byte_errs <= sat_inc(byte_errs);
        end else if (cidx == IW'(FRAME_LEN)) begin
          // one step past FRAME_LEN flags an overlong burst at its end
          cidx <= cidx + 1'b1;
        end
        default: cst <= C_IDLE;
      endcase
      if (start_acc) begin
        frames_rx <= '0;
        byte_errs <= '0;
        len_errs  <= '0;
      end
    end
  end
endmodule

// File: doc/gmii_traffic_gen_check.md
# gmii_traffic_gen_check

Parametrised GMII traffic generator and self-checker: the synthesizable successor to the fixed-stimulus tester used around the 1000BASE-X PCS chain (transmit, synchronization, receive). It drives framed TXD/TX_EN bursts (preamble, SFD, payload, IPG) into the transmit PCS and checks RXD/RX_DV from the receive PCS against an independently regenerated payload. Frame, byte and length-error counts are exported as counters. It serves as on-chip BIST and as the bench stimulus for every PCS regression.

## Interface
- FRAME_LEN, 8: payload bytes per frame, ≥1
- IPG, 12: TX_EN-low cycles between frames, ≥2
- NUM_FRAMES, 4: frames per run; 0 = continuous
- PREAMBLE_LEN, 7: 0x55 bytes before the SFD, ≥1
- CNT_W, 16: counter width

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle run request
- TXD  out  8  transmit data to the PCS
- TX_EN  out  1  transmit enable
- TX_ER  out  1  tied 0
- RX_DV  in  1  receive data valid from the PCS
- RXD  in  8  receive data from the PCS
- busy  out  1  generator not idle
- done  out  1  run complete (level)
- frames_tx  out  CNT_W  frames fully sent
- frames_rx  out  CNT_W  frames with SFD detected and ended
- byte_errs  out  CNT_W  payload byte mismatches
- len_errs  out  CNT_W  wrong-length or SFD-less bursts

## Operation
- Generator FSM: G_IDLE → G_PRE (PREAMBLE_LEN × 0x55) → G_SFD (0xD5) → G_DATA (FRAME_LEN bytes) → G_IPG (IPG cycles).
- TX_EN is high in G_PRE, G_SFD and G_DATA only. TXD is 0x00 when TX_EN is low.
- After G_IPG: go to G_PRE if more frames remain (or NUM_FRAMES = 0), otherwise go to G_IDLE.
- start is honoured only in G_IDLE and is ignored otherwise. Accepting start clears all four counters and done.
- Payload byte i of frame n (n = frame sequence number, low 8 bits):
  - default: (n + i) mod 256.
  - Generator uses frames_tx; checker uses frames_rx.
- Checker FSM: C_IDLE, C_HUNT, C_DATA.
  - C_IDLE: RX_DV rising → C_HUNT.
  - C_HUNT: RXD == 0xD5 → C_DATA with index 0. Any other byte is discarded, which tolerates preamble shortening by the PCS.
  - C_DATA: compare while index < FRAME_LEN. Each mismatch increments byte_errs. Bytes beyond FRAME_LEN are not compared.
  - RX_DV falling in C_DATA: frames_rx +1; if index ≠ FRAME_LEN, len_errs +1; go to C_IDLE.
  - RX_DV falling in C_HUNT: len_errs +1; frames_rx unchanged.
- All counters saturate at all-ones and never wrap.
- done = generator in G_IDLE, run started, NUM_FRAMES ≠ 0, frames_rx ≥ NUM_FRAMES. Held until the next accepted start or reset.
- busy = generator not in G_IDLE.

## Timing
- Reset (asynchronous, immediate): both FSMs go idle.
  - TXD = 0, TX_EN = 0, TX_ER = 0, busy = 0, done = 0, all counters 0.
  - Reset mid-frame truncates the burst the same instant; no partial counting.
- Outputs are registered.
- start is sampled at edge k:
  - TX_EN, busy = 1 from edge k+1.
  - First SFD at edge k+1+PREAMBLE_LEN.
- TX_EN is high for PREAMBLE_LEN+1+FRAME_LEN cycles, then low for exactly IPG cycles.
- frames_tx increments one cycle after the last payload byte.
- Checker counters update one cycle after the sampled RX_DV/RXD cycle.
- A frame end and a byte error on the same cycle both count.

## Configuration
- TGC_LFSR_PAYLOAD_EN defined: payload comes from an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  - Seed = n XOR 0xA5, loaded at SFD.
  - Advanced once per payload byte, both in the generator and in the checker.
- TGC_LFSR_PAYLOAD_EN undefined: incrementing payload (n + i).
- Counting, framing and timing are identical in both builds.

## Structure
- Package tgc_pkg holds:
  - generator and checker state enums,
  - PRE_BYTE = 8'h55, SFD_BYTE = 8'hD5,
  - LFSR taps and seed XOR constant.
- Sub-module tgc_payload_gen provides load(seq), step and an 8-bit byte output. It is instantiated twice: once for the generator, once for the checker.

## Test plan
- Defaults, TXD/TX_EN looped back to RXD/RX_DV through one register, start pulse → 4 bursts of 16 TX_EN-high cycles separated by 12 low. Result: frames_tx = frames_rx = 4, byte_errs = len_errs = 0, done = 1.
- Loopback, RXD XOR 0x01 on payload byte 3 of frame 2 → byte_errs = 1, len_errs = 0, frames_rx = 4.
- Loopback, RX_DV deasserted 2 bytes early on frame 1 → len_errs = 1, frames_rx = 4.
- Injected 10-cycle RX_DV burst of 0x55 only (no SFD) → len_errs +1, frames_rx unchanged.
- reset_n low mid-payload of frame 1 → all outputs 0 immediately. start after release → clean 4-frame run, zero errors.
- start pulsed while busy → ignored, 4 frames only. Full PCS chain (transmit → synchronization → receive) with FRAME_LEN = 64, NUM_FRAMES = 10 → frames_rx = 10, zero errors.
